bist_fsm: RTL and testbench
===========================

# bist_fsm

Built-in self-test controller for the serial link datapath. On request it switches the transceiver into loopback (`BIST_Mode`) and transmits a fixed sequence of byte patterns. It compares each looped-back byte against the byte sent and accumulates a saturating error count. It sits between the system control logic (`BIST_Start`/`BIST_Busy`/`BIST_Error`) and the UART transmitter/receiver (`Tx_Data`, `Transmit_Start`, `Rx_Data`, `Data_Rdy`).

## Interface
Parameters:
- `NUM_PATTERNS`, default 8: patterns per run, legal range 1..8.
- `TIMEOUT_CYCLES`, default 255: maximum wait for `Data_Rdy` per pattern. Only used with `BIST_TIMEOUT_EN`.

Ports:
- `ClK`  in  1  system clock; all logic on the rising edge.
- `Clear`  in  1  reset, synchronous and active-high.
- `BIST_Start`  in  1  request a test run; sampled in IDLE only.
- `Data_Rdy`  in  1  receiver has a valid byte on `Rx_Data`; sampled in WAIT only.
- `Rx_Data`  in  8  received byte.
- `BIST_Mode`  out  1  loopback enable to the transceiver.
- `Tx_Data`  out  8  byte to transmit.
- `Transmit_Start`  out  1  one-cycle transmit strobe.
- `BIST_Error`  out  3  mismatch count, saturating at 7.
- `BIST_Busy`  out  1  run in progress.

## Operation
- The state register is named `State`. It is an enumerated type declared in the order IDLE, LOAD, SEND, WAIT, CHECK, DONE, so state names are probe-able hierarchically.
- Pattern ROM, index 0..7: 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h01, 8'h80.
- **IDLE**: `BIST_Mode`=0, `BIST_Busy`=0, `Transmit_Start`=0.
  - If `BIST_Start`=1: clear `BIST_Error`, set index=0, go to LOAD.
- **LOAD**: `Tx_Data` <= ROM[index]; go to SEND.
- **SEND**: `Transmit_Start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- **WAIT**: on `Data_Rdy`=1, capture `Rx_Data` and go to CHECK. With timeout enabled, expiry goes to CHECK flagged as a failure.
- **CHECK**: a failure is a mismatch between the captured byte and `Tx_Data`, or a timeout. On failure, `BIST_Error` increments, saturating at 7.
  - If index == `NUM_PATTERNS`-1: go to DONE.
  - Otherwise: index+1, go to LOAD.
- **DONE**: one cycle with `BIST_Busy`=0, `BIST_Mode`=0; go to IDLE.
- `BIST_Mode` and `BIST_Busy` are 1 in LOAD, SEND, WAIT and CHECK.
- `BIST_Error` holds its final value until the next accepted `BIST_Start` or `Clear`.
- `Tx_Data` holds its last loaded value until the next LOAD.
- Ignored inputs:
  - `BIST_Start` outside IDLE.
  - `Data_Rdy` outside WAIT.
  - `Rx_Data` except when captured in WAIT.

## Timing
- Reset: `Clear`=1 at a rising edge forces State=IDLE, index=0, and all outputs to 0 (`Tx_Data`=8'h00, `BIST_Error`=3'b000).
- `Clear` takes priority over all other inputs at every state, including mid-run. The run is abandoned with no DONE cycle.
- `BIST_Mode`, `BIST_Busy` and `Transmit_Start` are decoded from `State` (Moore, glitch-free). `Tx_Data` and `BIST_Error` are registered.
- Run latency:
  - `BIST_Start` high at edge N → LOAD after N, SEND after N+1 (`Transmit_Start` high), WAIT after N+2.
  - `Data_Rdy` high at edge M in WAIT → CHECK after M; the next LOAD (or DONE) follows after M+1.
  - Minimum run length: 4 cycles per pattern plus 1 DONE cycle.
- `BIST_Start` held high continuously re-triggers a new run from IDLE, one cycle after DONE.
- `Data_Rdy` already high on entry to WAIT is accepted at the first WAIT edge.
- Saturation: 6→7 increments; at 7 the count stays 7.

## Configuration
- `BIST_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - When `TIMEOUT_CYCLES` cycles elapse without `Data_Rdy`, go to CHECK and count one error.
  - `Data_Rdy` on the expiry cycle counts as a normal reception.
- `BIST_TIMEOUT_EN` not defined: no counter; WAIT waits indefinitely for `Data_Rdy` (`Clear` is the only escape).

## Test plan
- Reset: `Clear`=1 for 2 cycles → State=IDLE and all outputs 0. Assert `Data_Rdy`=1 in IDLE → no state change.
- Clean loopback: pulse `BIST_Start` one cycle; the bench echoes `Tx_Data` on `Rx_Data` with `Data_Rdy` 2 cycles after each `Transmit_Start`.
  - Expect 8 `Transmit_Start` strobes carrying 00, FF, 55, AA, 0F, F0, 01, 80.
  - Expect `BIST_Error`=0 and `BIST_Busy` falling at DONE.
- Single fault: same as the clean loopback, but return 8'h54 for pattern 8'h55 → `BIST_Error`=1.
- Saturation: `Rx_Data` stuck at 8'h00 → 7 mismatches → `BIST_Error`=7.
  - Stuck at 8'h11 → 8 mismatches → `BIST_Error` still 7.
- Timeout (`BIST_TIMEOUT_EN`): never assert `Data_Rdy` → each WAIT lasts 255 cycles, final `BIST_Error`=7. Without the macro, State remains WAIT indefinitely.
- Abort and coverage: assert `Clear` in WAIT → IDLE next edge with outputs 0. Over the test set, every enumerated state value is visited at least once.

Source files
------------

// File: rtl/bist_fsm.sv
// Built-in self-test controller: loops a fixed byte-pattern set through the UART and counts mismatches.
// Define BIST_TIMEOUT_EN to bound each WAIT to TIMEOUT_CYCLES cycles (expiry counts as a failure).
module bist_fsm #(
  parameter int NUM_PATTERNS   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       ClK,
  input  logic       Clear,
  input  logic       BIST_Start,
  input  logic       Data_Rdy,
  input  logic [7:0] Rx_Data,
  output logic       BIST_Mode,
  output logic [7:0] Tx_Data,
  output logic       Transmit_Start,
  output logic [2:0] BIST_Error,
  output logic       BIST_Busy
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, CHECK, DONE} state_t;

  state_t     State;
  state_t     next_state;
  logic [2:0] index;
  logic [7:0] rx_byte;
  logic       last_pattern;
  logic       failed;

  function automatic logic [7:0] pattern(input logic [2:0] i);
    case (i)
      3'd0:    pattern = 8'h00;
      3'd1:    pattern = 8'hFF;
      3'd2:    pattern = 8'h55;
      3'd3:    pattern = 8'hAA;
      3'd4:    pattern = 8'h0F;
      3'd5:    pattern = 8'hF0;
      3'd6:    pattern = 8'h01;
      default: pattern = 8'h80;
    endcase
  endfunction

  assign last_pattern = (index == 3'(NUM_PATTERNS - 1));

`ifdef BIST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          expire;
  logic          timed_out;

  // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle; a Data_Rdy in that same cycle wins.
  assign expire = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ClK) begin
    if (Clear) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (State == SEND) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (State == WAIT && !Data_Rdy) begin
      if (expire) timed_out <= 1'b1;
      else        wait_cnt  <= wait_cnt + 1'b1;
    end
  end

  assign failed = timed_out || (rx_byte != Tx_Data);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign failed         = (rx_byte != Tx_Data);
`endif

  always_ff @(posedge ClK) begin
    if (Clear) State <= IDLE;
    else       State <= next_state;
  end

  // Moore decode: loopback/busy cover the active states only, not DONE.
  always_comb begin
    next_state     = State;
    BIST_Mode      = 1'b0;
    BIST_Busy      = 1'b0;
    Transmit_Start = 1'b0;
    case (State)
      IDLE: if (BIST_Start) next_state = LOAD;
      LOAD: begin
        BIST_Mode  = 1'b1;
        BIST_Busy  = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        BIST_Mode      = 1'b1;
        BIST_Busy      = 1'b1;
        Transmit_Start = 1'b1;
        next_state     = WAIT;
      end
      WAIT: begin
        BIST_Mode = 1'b1;
        BIST_Busy = 1'b1;
        if (Data_Rdy) next_state = CHECK;
`ifdef BIST_TIMEOUT_EN
        else if (expire) next_state = CHECK;
`endif
      end
      CHECK: begin
        BIST_Mode  = 1'b1;
        BIST_Busy  = 1'b1;
        next_state = last_pattern ? DONE : LOAD;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ClK) begin
    if (Clear) begin
      index      <= 3'd0;
      Tx_Data    <= 8'h00;
      BIST_Error <= 3'd0;
      rx_byte    <= 8'h00;
    end else begin
      case (State)
        IDLE: begin
          if (BIST_Start) begin
            BIST_Error <= 3'd0;
            index      <= 3'd0;
          end
        end
        LOAD: Tx_Data <= pattern(index);
        WAIT: if (Data_Rdy) rx_byte <= Rx_Data;
        CHECK: begin
          if (failed && BIST_Error != 3'd7) BIST_Error <= BIST_Error + 3'd1;
          if (!last_pattern) index <= index + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_fsm.sv
// Self-checking bench for bist_fsm: randomized loopback responses scored against a
// pattern-list model of the expected strobes, run length and saturating error count.
module tb_bist_fsm;

  localparam int NP      = 8;
  localparam int TIMEOUT = 255;

  logic       ClK = 1'b0;
  logic       Clear;
  logic       BIST_Start;
  logic       Data_Rdy;
  logic [7:0] Rx_Data;
  logic       BIST_Mode;
  logic [7:0] Tx_Data;
  logic       Transmit_Start;
  logic [2:0] BIST_Error;
  logic       BIST_Busy;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] visited = '0;
  logic [7:0] rom [8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h01, 8'h80};

  bist_fsm #(.NUM_PATTERNS(NP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .ClK           (ClK),
    .Clear         (Clear),
    .BIST_Start    (BIST_Start),
    .Data_Rdy      (Data_Rdy),
    .Rx_Data       (Rx_Data),
    .BIST_Mode     (BIST_Mode),
    .Tx_Data       (Tx_Data),
    .Transmit_Start(Transmit_Start),
    .BIST_Error    (BIST_Error),
    .BIST_Busy     (BIST_Busy)
  );

  always #5 ClK = ~ClK;

  // State encoding follows the declared enum order IDLE..DONE = 0..5.
  always @(negedge ClK) if (int'(dut.State) < 6) visited[int'(dut.State)] = 1'b1;

  task automatic tick();
    @(negedge ClK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_state"}, 32'(dut.State), 0);
    checkOutput({tag, "_mode"}, 32'(BIST_Mode), 0);
    checkOutput({tag, "_busy"}, 32'(BIST_Busy), 0);
    checkOutput({tag, "_ts"}, 32'(Transmit_Start), 0);
    checkOutput({tag, "_tx"}, 32'(Tx_Data), 0);
    checkOutput({tag, "_err"}, 32'(BIST_Error), 0);
  endtask

  // mode: 0 clean, 1 single fault on 8'h55, 2 stuck 00, 3 stuck 11, 4 random faults/delays, 5 no Data_Rdy
  task automatic applyStimulus(input int mode, input bit holdStart);
    logic [7:0] resp [8];
    int         delay [8];
    int         expErr;
    int         expCycles;
    int         k;
    int         rdyAt;
    logic [7:0] curResp;
    bit         done;
    for (int i = 0; i < NP; i++) begin
      resp[i]  = rom[i];
      delay[i] = (mode == 4) ? int'($urandom_range(1, 5)) : ((mode == 5) ? TIMEOUT : 2);
      case (mode)
        1: if (rom[i] == 8'h55) resp[i] = 8'h54;
        2: resp[i] = 8'h00;
        3: resp[i] = 8'h11;
        4: if ($urandom_range(0, 2) == 0) resp[i] = rom[i] ^ (8'd1 << $urandom_range(0, 7));
        default: ;
      endcase
    end
    expErr = 0;
    for (int i = 0; i < NP; i++) if (mode == 5 || resp[i] != rom[i]) expErr++;
    if (expErr > 7) expErr = 7;
    expCycles = 1;
    for (int i = 0; i < NP; i++) expCycles += 3 + delay[i];

    BIST_Start = 1'b1;
    k       = 0;
    rdyAt   = -1;
    curResp = 8'h00;
    done    = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      tick();
      Data_Rdy = 1'b0;
      Rx_Data  = 8'($urandom);
      if (cyc == 1) begin
        BIST_Start = holdStart;
        checkOutput("load_err_cleared", 32'(BIST_Error), 0);
        checkOutput("load_busy", 32'(BIST_Busy), 1);
      end
      if (Transmit_Start) begin
        checkOutput($sformatf("tx_pattern%0d", k), 32'(Tx_Data), 32'(rom[k % 8]));
        checkOutput("mode_in_send", 32'(BIST_Mode), 1);
        rdyAt   = (mode == 5) ? -1 : cyc + delay[k % 8];
        curResp = resp[k % 8];
        k++;
      end
      if (cyc == rdyAt) begin
        Data_Rdy = 1'b1;
        Rx_Data  = curResp;
      end
      if (cyc > 1 && !BIST_Busy) begin
        done = 1'b1;
        checkOutput("done_cycle", 32'(cyc), 32'(expCycles));
        checkOutput("done_state", 32'(dut.State), 5);
      end
    end
    if (!done) checkOutput("run_budget_expired", 0, 1);
    checkOutput("strobe_count", 32'(k), NP);
    checkOutput($sformatf("final_err_mode%0d", mode), 32'(BIST_Error), 32'(expErr));
    checkOutput("done_mode", 32'(BIST_Mode), 0);

    tick();
    checkOutput("after_done_idle", 32'(dut.State), 0);
    checkOutput("err_held", 32'(BIST_Error), 32'(expErr));
    if (holdStart) begin
      tick();
      checkOutput("retrigger_load", 32'(dut.State), 1);
      checkOutput("retrigger_busy", 32'(BIST_Busy), 1);
      Clear      = 1'b1;
      BIST_Start = 1'b0;
      tick();
      Clear = 1'b0;
      checkOutput("clear_in_load", 32'(dut.State), 0);
    end
  endtask

  initial begin
    bit seen;
    Clear      = 1'b1;
    BIST_Start = 1'b0;
    Data_Rdy   = 1'b0;
    Rx_Data    = 8'h00;
    tick();
    tick();
    Clear = 1'b0;
    checkIdleOutputs("reset");

    Data_Rdy = 1'b1;
    tick();
    tick();
    checkOutput("idle_ignores_rdy", 32'(dut.State), 0);
    Data_Rdy = 1'b0;

    applyStimulus(0, 1'b0);
    applyStimulus(1, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    for (int r = 0; r < 6; r++) applyStimulus(4, 1'b0);
    applyStimulus(0, 1'b1);
`ifdef BIST_TIMEOUT_EN
    applyStimulus(5, 1'b0);
`endif

    // Abort mid-run: answer pattern 0 wrongly, leave pattern 1 unanswered, then Clear in WAIT.
    BIST_Start = 1'b1;
    tick();
    BIST_Start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = Transmit_Start;
    end
    checkOutput("abort_strobe0", 32'(seen), 1);
    tick();
    Data_Rdy = 1'b1;
    Rx_Data  = 8'hEE;
    tick();
    Data_Rdy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = Transmit_Start;
    end
    checkOutput("abort_strobe1", 32'(seen), 1);
`ifdef BIST_TIMEOUT_EN
    for (int c = 0; c < 20; c++) tick();
`else
    for (int c = 0; c < 300; c++) tick();
`endif
    checkOutput("wait_holds", 32'(dut.State), 3);
    checkOutput("abort_tx", 32'(Tx_Data), 32'h FF);
    checkOutput("abort_err", 32'(BIST_Error), 1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    checkIdleOutputs("abort");

    checkOutput("state_coverage", 32'(visited), 32'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
